// File: rtl/uart_tx_ctrl.sv
// UART transmit controller: accepts a byte on valid/ready, loads the downstream
// PISO and paces its shift strobe, framing start/data/parity/stop on txd.
module uart_tx_ctrl #(
  parameter int CLKS_PER_BIT = 16,
  parameter bit PARITY_EN    = 1'b0,
  parameter bit PARITY_ODD   = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic [7:0] piso_din,
  output logic       piso_load,
  output logic       piso_shift,
  input  logic       piso_dout,
  output logic       txd,
  output logic       busy
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [2:0]    bit_idx;
  logic          parity_bit;
  logic          bit_end;

  assign bit_end = (cnt == CNT_LAST);

  // NOTE: every register here updates with <= so all of them sample the same
  // pre-edge values; mixing in = would make results depend on statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      bit_idx    <= '0;
      parity_bit <= 1'b0;
      piso_din   <= '0;
      piso_load  <= 1'b0;
    end else begin
      piso_load <= 1'b0;
      // Baud counter restarts on every state entry, including each new data bit.
      if (state != IDLE) cnt <= bit_end ? '0 : cnt + 1'b1;
      case (state)
        IDLE: begin
          if (tx_valid) begin
            piso_din   <= tx_data;
            piso_load  <= 1'b1;
            parity_bit <= (^tx_data) ^ PARITY_ODD;
            state      <= START;
          end
        end
        START: begin
          if (bit_end) begin
            state   <= DATA;
            bit_idx <= '0;
          end
        end
        DATA: begin
          if (bit_end) begin
            if (bit_idx == 3'd7) state <= PARITY_EN ? PARITY : STOP;
            else                 bit_idx <= bit_idx + 3'd1;
          end
        end
        PARITY: if (bit_end) state <= STOP;
        STOP:   if (bit_end) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // The shift leaving START presents bit 0; shifts at the end of bits 0..6
  // present bits 1..7, so the PISO sees exactly eight per frame.
  assign piso_shift = bit_end &&
                      ((state == START) || ((state == DATA) && (bit_idx != 3'd7)));

  assign tx_ready = (state == IDLE);
  assign busy     = ~tx_ready;

  // NOTE: txd gets a default before the case so no path leaves it unassigned,
  // which would otherwise infer a latch.
  always_comb begin
    txd = 1'b1;
    case (state)
      START:   txd = 1'b0;
      DATA:    txd = piso_dout;
      PARITY:  txd = parity_bit;
      default: txd = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Bench for uart_tx_ctrl: three instances (no parity, even, odd) at 4 clocks
// per bit, each feeding a behavioural PISO, checked against a frame model.
module tb_uart_tx_ctrl;

  localparam int N = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] tx_data = 8'h00;
  logic [2:0] tx_valid = 3'b000;
  logic [2:0] tx_ready, piso_load, piso_shift, piso_dout, txd, busy;
  logic [7:0] piso_din [3];

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  uart_tx_ctrl #(.CLKS_PER_BIT(N), .PARITY_EN(1'b0), .PARITY_ODD(1'b0)) dut0 (
    .clk(clk), .rst(rst), .tx_data(tx_data), .tx_valid(tx_valid[0]),
    .tx_ready(tx_ready[0]), .piso_din(piso_din[0]), .piso_load(piso_load[0]),
    .piso_shift(piso_shift[0]), .piso_dout(piso_dout[0]), .txd(txd[0]), .busy(busy[0])
  );

  uart_tx_ctrl #(.CLKS_PER_BIT(N), .PARITY_EN(1'b1), .PARITY_ODD(1'b0)) dut1 (
    .clk(clk), .rst(rst), .tx_data(tx_data), .tx_valid(tx_valid[1]),
    .tx_ready(tx_ready[1]), .piso_din(piso_din[1]), .piso_load(piso_load[1]),
    .piso_shift(piso_shift[1]), .piso_dout(piso_dout[1]), .txd(txd[1]), .busy(busy[1])
  );

  uart_tx_ctrl #(.CLKS_PER_BIT(N), .PARITY_EN(1'b1), .PARITY_ODD(1'b1)) dut2 (
    .clk(clk), .rst(rst), .tx_data(tx_data), .tx_valid(tx_valid[2]),
    .tx_ready(tx_ready[2]), .piso_din(piso_din[2]), .piso_load(piso_load[2]),
    .piso_shift(piso_shift[2]), .piso_dout(piso_dout[2]), .txd(txd[2]), .busy(busy[2])
  );

  // Right-shifting PISO whose dout register takes the low bit on each shift.
  for (genvar g = 0; g < 3; g++) begin : g_piso
    logic [7:0] sr;
    logic       d;
    always @(posedge clk or posedge rst) begin
      if (rst) begin
        sr <= 8'h00;
        d  <= 1'b0;
      end else if (piso_load[g]) begin
        sr <= piso_din[g];
      end else if (piso_shift[g]) begin
        d  <= sr[0];
        sr <= sr >> 1;
      end
    end
    assign piso_dout[g] = d;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic int frame_len(input int idx);
    return (idx == 0) ? 10 * N : 11 * N;
  endfunction

  // Line level of bit slot j of a frame carrying byte b on instance idx.
  function automatic logic exp_bit(input logic [7:0] b, input int j, input int idx);
    if (j == 0) return 1'b0;
    if (j <= 8) return b[j-1];
    if (j == 9 && idx != 0) return (^b) ^ (idx == 2);
    return 1'b1;
  endfunction

  task automatic start_frame(input int idx, input logic [7:0] b);
    int t = 0;
    while (tx_ready[idx] !== 1'b1 && t < 200) begin
      @(negedge clk);
      t++;
    end
    n_checks++;
    if (tx_ready[idx] !== 1'b1) begin
      n_fail++;
      $display("FAIL ready_timeout dut%0d: tx_ready=%b after %0d cycles, want 1", idx, tx_ready[idx], t);
    end
    tx_data       = b;
    tx_valid[idx] = 1'b1;
  endtask

  // Called at the negedge just before the accept edge; follows the frame to
  // the idle cycle after its stop bit.
  task automatic observe_frame(input int idx, input logic [7:0] b, input bit hold,
                               input bit inject, input logic [7:0] next_b,
                               output int fall_cyc);
    int f = frame_len(idx);
    int shifts = 0;
    int loads  = 0;
    fall_cyc = 0;
    for (int c = 0; c < f; c++) begin
      @(negedge clk);
      if (c == 0) begin
        fall_cyc = cyc;
        n_checks++;
        if (piso_din[idx] !== b) begin
          n_fail++;
          $display("FAIL piso_din dut%0d: got %h want %h", idx, piso_din[idx], b);
        end
        if (hold) tx_data = next_b;
        else      tx_valid[idx] = 1'b0;
      end
      if (inject && c == 3 * N + 1) begin
        tx_data       = 8'h3C;
        tx_valid[idx] = 1'b1;
      end
      if (inject && c == 3 * N + 2) tx_valid[idx] = 1'b0;
      n_checks++;
      if (txd[idx] !== exp_bit(b, c / N, idx)) begin
        n_fail++;
        $display("FAIL txd dut%0d byte %h slot %0d cycle %0d: got %b want %b",
                 idx, b, c / N, c, txd[idx], exp_bit(b, c / N, idx));
      end
      n_checks++;
      if (tx_ready[idx] !== 1'b0 || busy[idx] !== 1'b1) begin
        n_fail++;
        $display("FAIL busy_frame dut%0d cycle %0d: ready=%b busy=%b want 0/1",
                 idx, c, tx_ready[idx], busy[idx]);
      end
      n_checks++;
      if ((piso_load[idx] & piso_shift[idx]) !== 1'b0) begin
        n_fail++;
        $display("FAIL load_shift_overlap dut%0d cycle %0d: got 1 want 0", idx, c);
      end
      if (c >= f - N) begin
        n_checks++;
        if (piso_shift[idx] !== 1'b0) begin
          n_fail++;
          $display("FAIL shift_in_stop dut%0d cycle %0d: got %b want 0", idx, c, piso_shift[idx]);
        end
      end
      if (piso_load[idx] === 1'b1)  loads++;
      if (piso_shift[idx] === 1'b1) shifts++;
    end
    n_checks++;
    if (loads != 1) begin
      n_fail++;
      $display("FAIL load_count dut%0d: got %0d want 1", idx, loads);
    end
    n_checks++;
    if (shifts != 8) begin
      n_fail++;
      $display("FAIL shift_count dut%0d: got %0d want 8", idx, shifts);
    end
    @(negedge clk);
    n_checks++;
    if (txd[idx] !== 1'b1 || tx_ready[idx] !== 1'b1 || busy[idx] !== 1'b0 || piso_shift[idx] !== 1'b0) begin
      n_fail++;
      $display("FAIL idle_after dut%0d: txd=%b ready=%b busy=%b shift=%b want 1/1/0/0",
               idx, txd[idx], tx_ready[idx], busy[idx], piso_shift[idx]);
    end
  endtask

  task automatic check_reset_values(input string tag);
    n_checks++;
    if (txd !== 3'b111 || tx_ready !== 3'b111 || busy !== 3'b000 ||
        piso_load !== 3'b000 || piso_shift !== 3'b000) begin
      n_fail++;
      $display("FAIL %s: txd=%b ready=%b busy=%b load=%b shift=%b want 111/111/000/000/000",
               tag, txd, tx_ready, busy, piso_load, piso_shift);
    end
  endtask

  task automatic test_reset();
    #2;
    check_reset_values("reset_outputs");
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if (piso_din[i] !== 8'h00) begin
        n_fail++;
        $display("FAIL reset_din dut%0d: got %h want 00", i, piso_din[i]);
      end
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_single_frame();
    int fc;
    start_frame(0, 8'hA5);
    observe_frame(0, 8'hA5, 1'b0, 1'b0, 8'h00, fc);
  endtask

  task automatic test_parity();
    int fc;
    start_frame(1, 8'h07);
    observe_frame(1, 8'h07, 1'b0, 1'b0, 8'h00, fc);
    start_frame(2, 8'h07);
    observe_frame(2, 8'h07, 1'b0, 1'b0, 8'h00, fc);
    start_frame(1, 8'h03);
    observe_frame(1, 8'h03, 1'b0, 1'b0, 8'h00, fc);
  endtask

  task automatic test_back_to_back();
    int fc1, fc2;
    start_frame(0, 8'h00);
    observe_frame(0, 8'h00, 1'b1, 1'b0, 8'hFF, fc1);
    observe_frame(0, 8'hFF, 1'b0, 1'b0, 8'h00, fc2);
    n_checks++;
    if (fc2 - fc1 != 10 * N + 1) begin
      n_fail++;
      $display("FAIL b2b_period: got %0d cycles want %0d", fc2 - fc1, 10 * N + 1);
    end
  endtask

  task automatic test_ignore_midframe();
    int fc;
    start_frame(0, 8'h5A);
    observe_frame(0, 8'h5A, 1'b0, 1'b1, 8'h00, fc);
    @(negedge clk);
    n_checks++;
    if (tx_ready[0] !== 1'b1 || txd[0] !== 1'b1) begin
      n_fail++;
      $display("FAIL ignore_no_accept: ready=%b txd=%b want 1/1", tx_ready[0], txd[0]);
    end
  endtask

  task automatic test_reset_midframe();
    int fc;
    tx_data  = 8'hF0;
    tx_valid = 3'b111;
    @(negedge clk);
    tx_valid = 3'b000;
    repeat (4 * N + 2) @(negedge clk);
    n_checks++;
    if (txd !== 3'b000) begin
      n_fail++;
      $display("FAIL pre_reset_bit3: got %b want 000", txd);
    end
    #2 rst = 1'b1;
    #1 check_reset_values("reset_async_midframe");
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_reset_values("reset_held");
    end
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      start_frame(i, 8'h81);
      observe_frame(i, 8'h81, 1'b0, 1'b0, 8'h00, fc);
    end
  endtask

  task automatic test_random();
    int fc;
    logic [7:0] b;
    for (int i = 0; i < 3; i++) begin
      for (int k = 0; k < 4; k++) begin
        b = 8'($urandom);
        repeat ($urandom_range(0, 3)) @(negedge clk);
        start_frame(i, b);
        observe_frame(i, b, 1'b0, 1'b0, 8'h00, fc);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_parity();
    test_back_to_back();
    test_ignore_midframe();
    test_reset_midframe();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_tx_ctrl.md
# uart_tx_ctrl

UART transmit controller. Sits directly upstream of the 8-bit PISO shifter in the TX path. Accepts a byte over a valid/ready handshake, loads it into the PISO, and paces the PISO's `shift` at the baud rate. Drives the serial line with start bit, 8 data bits LSB-first (taken from PISO `dout`), optional parity and one stop bit.

## Interface
- `CLKS_PER_BIT`, 16, clk cycles per bit period; legal range 2 or more.
- `PARITY_EN`, 0, 1 inserts a parity bit between data and stop.
- `PARITY_ODD`, 0, 0 selects even parity, 1 selects odd; ignored when `PARITY_EN` = 0.
- `clk`  in  1  single clock; all state changes on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `tx_data`  in  8  byte to send; sampled only in the accept cycle.
- `tx_valid`  in  1  byte available.
- `tx_ready`  out  1  controller can accept a byte.
- `piso_din`  out  8  registered byte presented to PISO `din`.
- `piso_load`  out  1  registered one-cycle load pulse to PISO.
- `piso_shift`  out  1  shift strobe to PISO.
- `piso_dout`  in  1  PISO serial output (current data bit).
- `txd`  out  1  serial line; idle high.
- `busy`  out  1  frame in progress.

## Operation
- States: IDLE, START, DATA, PARITY, STOP.
- Internal counters:
  - baud counter `cnt`, 0 to CLKS_PER_BIT-1, cleared on every state entry;
  - bit index `bit_idx`, 3 bits.
- Outputs by state:
  - `tx_ready` = (state == IDLE); `busy` = !`tx_ready`.
  - `txd`: IDLE 1, START 0, DATA `piso_dout`, PARITY stored parity bit, STOP 1.
  - `txd` is a mux of registered signals only.
- Accept happens on a rising edge with state IDLE and `tx_valid` = 1. On that edge:
  - `piso_din` <= `tx_data`;
  - `piso_load` <= 1 for exactly one cycle;
  - parity <= ^`tx_data` XOR `PARITY_ODD`;
  - state <= START.
- `tx_valid` outside IDLE is ignored. No byte is dropped or duplicated.
- `piso_shift` = ((state == START) or (state == DATA and `bit_idx` != 7)) and `cnt` == CLKS_PER_BIT-1.
  - This gives exactly 8 shifts per frame.
  - Each shift edge coincides with entry into the next data bit, so `piso_dout` presents bit k for all of data period k.
  - The PISO's `dout` updates on the shift edge, and it shifts right, so bits go out LSB first.
- Transitions, each taken when `cnt` == CLKS_PER_BIT-1:
  - START → DATA, `bit_idx` <= 0.
  - DATA with `bit_idx` < 7: stay in DATA, `bit_idx` + 1.
  - DATA with `bit_idx` == 7: → PARITY if `PARITY_EN`, else → STOP.
  - PARITY → STOP.
  - STOP → IDLE.
- `piso_load` and `piso_shift` are never asserted in the same cycle.
- `piso_shift` is never asserted in IDLE or STOP.

## Timing
- Reset values (asserted asynchronously, held while `rst` = 1):
  - state IDLE, `txd` 1, `tx_ready` 1, `busy` 0;
  - `piso_load` 0, `piso_shift` 0, `piso_din` 8'h00;
  - `cnt` 0, `bit_idx` 0, parity 0.
- Reset mid-frame: `txd` returns to 1 immediately. The frame is abandoned; no partial stop bit is sent. The PISO shares `rst`.
- Accept edge is T0. Line timing with N = `CLKS_PER_BIT`:
  - `txd` falls at T0.
  - `piso_load` is high in cycle T0 to T0+1; the PISO is loaded at T0+1.
  - Start bit spans N cycles.
  - Data bit k starts at T0+(1+k)·N.
  - Parity starts at T0+9N (when enabled).
  - Stop ends at T0+(10+P)·N, where P = `PARITY_EN`; the FSM is in IDLE from there.
- Streaming with `tx_valid` held high: one IDLE cycle between frames (`txd` = 1). Frame period = (10+P)·N + 1 cycles.
- Input-to-line latency: `txd` low on the same edge that accepts.

## Test plan
- Reset: assert `rst` asynchronously between edges → `txd` = 1, `tx_ready` = 1, `piso_load` = `piso_shift` = 0, before the next clk edge.
- Single frame, N=4, no parity, 0xA5 → `txd` bits, one per 4 cycles: 0,1,0,1,0,0,1,0,1,1. Exactly 8 `piso_shift` pulses; one `piso_load` pulse with `piso_din` = 0xA5; `tx_ready` low for 40 cycles.
- Parity, N=4, `PARITY_EN`=1: 0x07 even → parity bit 1; 0x07 odd → 0; 0x03 even → 0. Frame is 44 cycles.
- Back-to-back, `tx_valid` held, 0x00 then 0xFF → second start bit falls exactly 41 cycles after the first (N=4). Exactly one idle-high cycle between frames.
- `tx_valid` pulsed with 0x3C mid-frame → ignored. The line carries only the original byte, and `tx_ready` stays 0 until the stop bit completes.
- `rst` asserted during data bit 3, then released; send 0x81 → `txd` high throughout reset. The next frame is correct (1,0,0,0,0,0,0,1 data) with no stale shifts.
